ex_hazard_sched: RTL and testbench
==================================

# ex_hazard_sched

Pipeline hazard and execute-resource scheduler that sits beside the execute stage and decides, each cycle, whether the front end advances, stalls, or is flushed. It detects load-use hazards, sequences multi-cycle multiply/divide operations that occupy the execute ALU, and turns taken branches into front-end flushes. It also keeps a free-running stall-cycle performance counter. Forwarding stays in the execute stage; this block only covers hazards that forwarding cannot resolve.

## Interface
- MUL_LAT, 4, total execute cycles of a multiply (≥2)
- DIV_LAT, 32, total execute cycles of a divide (≥2, ≥MUL_LAT)
- clk_i  in  1  clock; all state changes on the rising edge
- reset_i  in  1  asynchronous, active-low reset
- id_rs1_i, id_rs2_i  in  5 each  source registers of the instruction in decode
- id_use_rs1_i, id_use_rs2_i  in  1 each  decode instruction actually reads rs1 / rs2
- ex_valid_i  in  1  execute stage holds a real instruction
- ex_rd_i  in  5  destination register of the execute instruction
- ex_memread_i  in  1  execute instruction is a load
- ex_multi_i  in  1  execute instruction is a multi-cycle op
- ex_is_div_i  in  1  multi-cycle op is a divide (else multiply)
- ex_branch_taken_i  in  1  branch/jump resolved taken in execute
- stall_if_o, stall_id_o  out  1 each  hold the PC and the IF/ID register
- stall_ex_o  out  1  hold the ID/EX register
- bubble_ex_o  out  1  load a NOP into ID/EX at the next edge
- bubble_mem_o  out  1  load a NOP into EX/MEM at the next edge
- flush_if_id_o, flush_id_ex_o  out  1 each  squash the younger instructions
- pc_sel_branch_o  out  1  PC takes the branch target at the next edge
- md_start_o  out  1  one-cycle pulse: start the multiply/divide datapath
- md_busy_o  out  1  a multi-cycle op is in progress
- md_done_o  out  1  one-cycle pulse: the result is valid this cycle
- stall_cnt_o  out  32  count of cycles in which stall_if_o was high

## Operation
- FSM states: RUN, MULTI.
- RUN, evaluated in priority order, with all conditions qualified by ex_valid_i:
  - ex_branch_taken_i: assert flush_if_id_o, flush_id_ex_o and pc_sel_branch_o; assert no stall. A taken branch is never also a multi-cycle op.
  - ex_multi_i: assert md_start_o, stall_if_o, stall_id_o, stall_ex_o and bubble_mem_o. Load the counter with (ex_is_div_i ? DIV_LAT : MUL_LAT) − 2, then go to MULTI.
  - Load-use hazard: ex_memread_i and ex_rd_i≠0 and ((id_use_rs1_i and ex_rd_i==id_rs1_i) or (id_use_rs2_i and ex_rd_i==id_rs2_i)). Assert stall_if_o, stall_id_o and bubble_ex_o for exactly one cycle.
  - Otherwise assert nothing.
- MULTI:
  - md_busy_o is high.
  - While counter≠0: stall_if_o, stall_id_o, stall_ex_o and bubble_mem_o are high, and the counter decrements.
  - When counter==0: md_done_o pulses, all stalls drop so the op advances to EX/MEM, and the FSM returns to RUN.
  - Decode and branch inputs are ignored in MULTI.
- A multi-cycle op therefore occupies execute for exactly its LAT cycles, from the md_start_o cycle through the md_done_o cycle inclusive.
- stall_cnt_o increments by 1 every cycle in which stall_if_o is high. It wraps from 0xFFFF_FFFF to 0.
- ex_valid_i low in RUN: every output is 0 and the state is unchanged.

## Timing
- The control outputs are combinational from state plus inputs, resolved in the same cycle. md_busy_o and stall_cnt_o are registered.
- Reset, asynchronous while reset_i is low:
  - State is RUN, counter is 0, stall_cnt_o is 0.
  - Every combinational output is gated to 0.
- Reset asserted during MULTI aborts the op. No md_done_o is produced, and after release the block starts in RUN.
- Back-to-back multi-cycle ops: the cycle after md_done_o is RUN. If the next EX instruction is also multi, md_start_o fires in that cycle; there is no idle gap.
- A load-use stall lasts one cycle. In the following cycle the load has left EX, so the hazard clears and no extra bubble is inserted.

## Structure
- Package ex_ctrl_pkg:
  - sched_state_e enum {RUN, MULTI}
  - default latency localparams MUL_LAT_DEF=4, DIV_LAT_DEF=32
  - CNT_W = $clog2(DIV_LAT)
- One sub-module, lat_down_counter:
  - loadable down-counter with a zero flag, width CNT_W
  - asynchronous active-low reset

## Test plan
- Load x5 in EX; ID `add x6,x5,x1` with id_use_rs1_i=1 → stall_if_o/stall_id_o/bubble_ex_o high for 1 cycle, stall_cnt_o 0→1. Same case with ex_rd_i=0 → no stall.
- Multiply with MUL_LAT=4 → md_start_o at cycle 0, stalls high in cycles 0–2, md_done_o at cycle 3, stall_cnt_o +=3.
- Divide with DIV_LAT=32 immediately followed by a multiply → md_done_o at cycle 31, md_start_o at cycle 32, md_busy_o registered high across both ops.
- Load-use condition and ex_branch_taken_i together → flushes and pc_sel_branch_o only; no stall; stall_cnt_o unchanged.
- reset_i low in cycle 10 of a divide → outputs 0 immediately; after release the state is RUN and md_done_o never pulses.
- stall_cnt_o preset near wrap by driving 2^32 stall cycles (or a forced value 0xFFFF_FFFF) → next stall cycle gives 0.

Source files
------------

// File: rtl/ex_ctrl_pkg.sv
// Shared types and defaults for the execute-stage hazard scheduler.
// Latency: n/a (types only); backpressure: n/a.
package ex_ctrl_pkg;

    typedef enum logic {
        RUN   = 1'b0,
        MULTI = 1'b1
    } sched_state_e;

    localparam int MUL_LAT_DEF = 4;
    localparam int DIV_LAT_DEF = 32;
    localparam int CNT_W       = $clog2(DIV_LAT_DEF);

    // Counter width for a given longest latency; the counter never holds more than lat-2.
    function automatic int lat_cnt_w(input int lat);
        return (lat < 2) ? 1 : $clog2(lat);
    endfunction

endpackage

// File: rtl/ex_hazard_sched_lat_down_counter.sv
// Loadable down-counter with zero flag, sequences multi-cycle execute ops.
// Latency: load/decrement visible next cycle; backpressure: none, saturates at zero.
module lat_down_counter #(
    parameter int W = 5
) (
    input  logic         clk_i,
    input  logic         reset_i,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/ex_hazard_sched.sv
// Stall/flush/bubble control beside EX: load-use, mul/div occupancy, taken branches.
// Latency: controls combinational same-cycle; backpressure: produces stalls, consumes none.
module ex_hazard_sched
    import ex_ctrl_pkg::*;
#(
    parameter int MUL_LAT = MUL_LAT_DEF,
    parameter int DIV_LAT = DIV_LAT_DEF
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic [4:0]  id_rs1_i,
    input  logic [4:0]  id_rs2_i,
    input  logic        id_use_rs1_i,
    input  logic        id_use_rs2_i,
    input  logic        ex_valid_i,
    input  logic [4:0]  ex_rd_i,
    input  logic        ex_memread_i,
    input  logic        ex_multi_i,
    input  logic        ex_is_div_i,
    input  logic        ex_branch_taken_i,
    output logic        stall_if_o,
    output logic        stall_id_o,
    output logic        stall_ex_o,
    output logic        bubble_ex_o,
    output logic        bubble_mem_o,
    output logic        flush_if_id_o,
    output logic        flush_id_ex_o,
    output logic        pc_sel_branch_o,
    output logic        md_start_o,
    output logic        md_busy_o,
    output logic        md_done_o,
    output logic [31:0] stall_cnt_o
);

    localparam int CW = lat_cnt_w(DIV_LAT);

    sched_state_e  state_q;
    logic          cnt_zero;
    logic          lu_hazard;
    logic [CW-1:0] load_val;

    assign lu_hazard = ex_memread_i && (ex_rd_i != 5'd0) &&
                       ((id_use_rs1_i && (ex_rd_i == id_rs1_i)) ||
                        (id_use_rs2_i && (ex_rd_i == id_rs2_i)));

    // Counter holds LAT-2 so the done cycle lands on the LAT-th cycle of the op.
    assign load_val = ex_is_div_i ? CW'(DIV_LAT - 2) : CW'(MUL_LAT - 2);

    lat_down_counter #(
        .W (CW)
    ) u_lat_cnt (
        .clk_i    (clk_i),
        .reset_i  (reset_i),
        .load     (md_start_o),
        .load_val (load_val),
        .dec      (state_q == MULTI),
        .zero     (cnt_zero)
    );

    always_comb begin
        stall_if_o      = 1'b0;
        stall_id_o      = 1'b0;
        stall_ex_o      = 1'b0;
        bubble_ex_o     = 1'b0;
        bubble_mem_o    = 1'b0;
        flush_if_id_o   = 1'b0;
        flush_id_ex_o   = 1'b0;
        pc_sel_branch_o = 1'b0;
        md_start_o      = 1'b0;
        md_done_o       = 1'b0;
        if (reset_i) begin
            if (state_q == MULTI) begin
                if (!cnt_zero) begin
                    stall_if_o   = 1'b1;
                    stall_id_o   = 1'b1;
                    stall_ex_o   = 1'b1;
                    bubble_mem_o = 1'b1;
                end else begin
                    md_done_o = 1'b1;
                end
            end else if (ex_valid_i) begin
                if (ex_branch_taken_i) begin
                    flush_if_id_o   = 1'b1;
                    flush_id_ex_o   = 1'b1;
                    pc_sel_branch_o = 1'b1;
                end else if (ex_multi_i) begin
                    md_start_o   = 1'b1;
                    stall_if_o   = 1'b1;
                    stall_id_o   = 1'b1;
                    stall_ex_o   = 1'b1;
                    bubble_mem_o = 1'b1;
                end else if (lu_hazard) begin
                    stall_if_o  = 1'b1;
                    stall_id_o  = 1'b1;
                    bubble_ex_o = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state_q     <= RUN;
            stall_cnt_o <= '0;
        end else begin
            stall_cnt_o <= stall_cnt_o + 32'(stall_if_o);
            case (state_q)
                RUN:     if (md_start_o) state_q <= MULTI;
                MULTI:   if (md_done_o)  state_q <= RUN;
                default: state_q <= RUN;
            endcase
        end
    end

    assign md_busy_o = (state_q == MULTI);

endmodule

// File: tb/tb_ex_hazard_sched.sv
// Self-checking bench for ex_hazard_sched: directed scenarios then random traffic vs a cycle model.
// Latency: n/a; backpressure: n/a.
module tb_ex_hazard_sched;

    localparam int MUL_LAT = 4;
    localparam int DIV_LAT = 32;

    logic        clk_i = 1'b0;
    logic        reset_i;
    logic [4:0]  id_rs1_i, id_rs2_i, ex_rd_i;
    logic        id_use_rs1_i, id_use_rs2_i;
    logic        ex_valid_i, ex_memread_i, ex_multi_i, ex_is_div_i, ex_branch_taken_i;
    logic        stall_if_o, stall_id_o, stall_ex_o, bubble_ex_o, bubble_mem_o;
    logic        flush_if_id_o, flush_id_ex_o, pc_sel_branch_o;
    logic        md_start_o, md_busy_o, md_done_o;
    logic [31:0] stall_cnt_o;

    ex_hazard_sched #(.MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)) dut (
        .clk_i             (clk_i),
        .reset_i           (reset_i),
        .id_rs1_i          (id_rs1_i),
        .id_rs2_i          (id_rs2_i),
        .id_use_rs1_i      (id_use_rs1_i),
        .id_use_rs2_i      (id_use_rs2_i),
        .ex_valid_i        (ex_valid_i),
        .ex_rd_i           (ex_rd_i),
        .ex_memread_i      (ex_memread_i),
        .ex_multi_i        (ex_multi_i),
        .ex_is_div_i       (ex_is_div_i),
        .ex_branch_taken_i (ex_branch_taken_i),
        .stall_if_o        (stall_if_o),
        .stall_id_o        (stall_id_o),
        .stall_ex_o        (stall_ex_o),
        .bubble_ex_o       (bubble_ex_o),
        .bubble_mem_o      (bubble_mem_o),
        .flush_if_id_o     (flush_if_id_o),
        .flush_id_ex_o     (flush_id_ex_o),
        .pc_sel_branch_o   (pc_sel_branch_o),
        .md_start_o        (md_start_o),
        .md_busy_o         (md_busy_o),
        .md_done_o         (md_done_o),
        .stall_cnt_o       (stall_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    int          n_checks = 0;
    int          n_errors = 0;

    // Model: cycles of the current mul/div still to run after its start cycle.
    int          md_left = 0;
    int unsigned sc_m    = 0;

    // Control snapshot layout: {si, sd, se, bex, bmem, fif, fie, pc, start, done}
    logic [9:0]  snap_ctl;
    logic        snap_busy;
    logic [31:0] snap_cnt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [9:0] model_ctl();
        logic [9:0] e = '0;
        logic hz;
        if (!reset_i) return '0;
        if (md_left > 0) begin
            if (md_left == 1) e = 10'b00000_00001;
            else              e = 10'b11101_00000;
        end else if (ex_valid_i) begin
            hz = ex_memread_i && (ex_rd_i != 0) &&
                 ((id_use_rs1_i && ex_rd_i == id_rs1_i) || (id_use_rs2_i && ex_rd_i == id_rs2_i));
            if (ex_branch_taken_i)  e = 10'b00000_11100;
            else if (ex_multi_i)    e = 10'b11101_00010;
            else if (hz)            e = 10'b11010_00000;
        end
        return e;
    endfunction

    task automatic cycle(input string tag);
        logic [9:0] e;
        @(negedge clk_i);
        if (!reset_i) begin
            md_left = 0;
            sc_m    = 0;
        end
        e         = model_ctl();
        snap_ctl  = {stall_if_o, stall_id_o, stall_ex_o, bubble_ex_o, bubble_mem_o,
                     flush_if_id_o, flush_id_ex_o, pc_sel_branch_o, md_start_o, md_done_o};
        snap_busy = md_busy_o;
        snap_cnt  = stall_cnt_o;
        chk({tag, "_ctl"},  32'(snap_ctl),  32'(e));
        chk({tag, "_busy"}, 32'(snap_busy), 32'(md_left > 0));
        chk({tag, "_cnt"},  snap_cnt,        sc_m);
        @(posedge clk_i);
        if (reset_i) begin
            if (e[9]) sc_m = sc_m + 1;
            if (md_left > 0)   md_left = md_left - 1;
            else if (e[1])     md_left = (ex_is_div_i ? DIV_LAT : MUL_LAT) - 1;
        end
        #1;
    endtask

    task automatic set_ex(input logic v, input logic [4:0] rd, input logic mr,
                          input logic mul, input logic dv, input logic br);
        ex_valid_i = v; ex_rd_i = rd; ex_memread_i = mr;
        ex_multi_i = mul; ex_is_div_i = dv; ex_branch_taken_i = br;
    endtask

    task automatic set_id(input logic [4:0] r1, input logic [4:0] r2, input logic u1, input logic u2);
        id_rs1_i = r1; id_rs2_i = r2; id_use_rs1_i = u1; id_use_rs2_i = u2;
    endtask

    int unsigned cnt0;
    int          done_seen;

    initial begin
        reset_i = 1'b0;
        set_id(5'd0, 5'd0, 1'b0, 1'b0);
        set_ex(1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        cycle("rst0");
        set_ex(1'b1, 5'd3, 1'b0, 1'b1, 1'b0, 1'b0);
        cycle("rst1");
        chk("rst_gated", 32'(snap_ctl), 32'd0);
        chk("rst_cnt", snap_cnt, 32'd0);
        reset_i = 1'b1;
        set_ex(1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        cycle("idle");

        // Load x5 in EX, decode add x6,x5,x1
        set_id(5'd5, 5'd1, 1'b1, 1'b1);
        set_ex(1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
        cycle("lu");
        chk("lu_vec", 32'(snap_ctl), 32'(10'b11010_00000));
        set_ex(1'b1, 5'd6, 1'b0, 1'b0, 1'b0, 1'b0);
        cycle("lu_next");
        chk("lu_clear", 32'(snap_ctl), 32'd0);
        chk("lu_cnt", snap_cnt, 32'd1);

        set_id(5'd0, 5'd1, 1'b1, 1'b1);
        set_ex(1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        cycle("lu_x0");
        chk("lu_x0_vec", 32'(snap_ctl), 32'd0);

        // Multiply
        cnt0 = stall_cnt_o;
        set_ex(1'b1, 5'd3, 1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < MUL_LAT; i++) begin
            cycle("mul");
            if (i == 0)           chk("mul_start", 32'(snap_ctl[1]), 32'd1);
            if (i < MUL_LAT - 1)  chk("mul_stall", 32'(snap_ctl[9]), 32'd1);
            if (i == MUL_LAT - 1) chk("mul_done", 32'(snap_ctl[0]), 32'd1);
            if (i == MUL_LAT - 1) set_ex(1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        end
        cycle("mul_after");
        chk("mul_cnt", snap_cnt - cnt0, 32'd3);

        // Divide immediately followed by multiply
        set_ex(1'b1, 5'd4, 1'b0, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < DIV_LAT + MUL_LAT; i++) begin
            cycle("divmul");
            if (i == 0) set_ex(1'b1, 5'd4, 1'b0, 1'b1, 1'b0, 1'b0);
            if (i == DIV_LAT - 1) chk("div_done", 32'(snap_ctl[0]), 32'd1);
            if (i == DIV_LAT)     chk("mul2_start", 32'(snap_ctl[1]), 32'd1);
            if (i == DIV_LAT)     set_ex(1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
            if ((i >= 1 && i < DIV_LAT) || i > DIV_LAT) chk("divmul_busy", 32'(snap_busy), 32'd1);
        end
        chk("mul2_done", 32'(snap_ctl[0]), 32'd1);

        // Load-use together with a taken branch
        cnt0 = stall_cnt_o;
        set_id(5'd4, 5'd0, 1'b1, 1'b0);
        set_ex(1'b1, 5'd4, 1'b1, 1'b0, 1'b0, 1'b1);
        cycle("br_lu");
        chk("br_lu_vec", 32'(snap_ctl), 32'(10'b00000_11100));
        set_ex(1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        cycle("br_after");
        chk("br_cnt", snap_cnt, cnt0);

        // Reset in cycle 10 of a divide
        set_ex(1'b1, 5'd2, 1'b0, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 10; i++) cycle("div_pre");
        reset_i = 1'b0;
        cycle("div_rst");
        chk("div_rst_ctl", 32'(snap_ctl), 32'd0);
        chk("div_rst_busy", 32'(snap_busy), 32'd0);
        set_ex(1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        cycle("div_rst2");
        reset_i = 1'b1;
        done_seen = 0;
        for (int i = 0; i < DIV_LAT + 8; i++) begin
            cycle("post_rst");
            if (snap_ctl[0] || snap_busy) done_seen++;
        end
        chk("post_rst_quiet", 32'(done_seen), 32'd0);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            logic mul;
            mul = ($urandom_range(0, 15) == 0);
            set_id(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                   1'($urandom), 1'($urandom));
            set_ex(($urandom_range(0, 3) != 0), 5'($urandom_range(0, 3)),
                   1'($urandom), mul, 1'($urandom_range(0, 3) == 0),
                   !mul && ($urandom_range(0, 7) == 0));
            cycle("rnd");
        end

        // Drain, then preset the stall counter just below wrap
        set_ex(1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < DIV_LAT + 2; i++) cycle("drain");
        force dut.stall_cnt_o = 32'hFFFF_FFFF;
        #1;
        release dut.stall_cnt_o;
        sc_m = 32'hFFFF_FFFF;
        set_id(5'd7, 5'd0, 1'b1, 1'b0);
        set_ex(1'b1, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0);
        cycle("wrap_pre");
        set_ex(1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        cycle("wrap_post");
        chk("wrap_zero", snap_cnt, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
